// File: rtl/vliw_lsu.sv
// vliw_lsu: load/store stage behind the three VLIW execution units.
// Captures one bundle of per-slot memory requests, then plays them out in slot
// order as byte beats on a single external handshake bus. Load results go back
// to the register file as writeback pulses. busy stalls the core until the
// bundle retires.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses are
// skipped and flagged on err. When the macro is undefined, err is tied low.
module vliw_lsu #(
    parameter int NUM_SLOTS = 3,
    parameter int REG_IDX_W = 5
) (
    input  logic                           wb_clk_i,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [NUM_SLOTS-1:0]           req_load,
    input  logic [NUM_SLOTS-1:0]           req_store,
    input  logic [32*NUM_SLOTS-1:0]        req_addr,
    input  logic [32*NUM_SLOTS-1:0]        req_wdata,
    input  logic [2*NUM_SLOTS-1:0]         req_size,
    input  logic [NUM_SLOTS-1:0]           req_sext,
    input  logic [REG_IDX_W*NUM_SLOTS-1:0] req_dest,
    output logic                           busy,
    output logic                           done,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [31:0]                    mem_addr,
    output logic [7:0]                     mem_wdata,
    input  logic [7:0]                     mem_rdata,
    input  logic                           mem_ready,
    output logic                           wb_valid,
    output logic [REG_IDX_W-1:0]           wb_idx,
    output logic [31:0]                    wb_val,
    output logic                           err
);

    localparam int PTR_W = $clog2(NUM_SLOTS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_XFER,
        S_WB,
        S_DONE
    } state_t;

    state_t               state;
    logic [PTR_W-1:0]     ptr;

    // Captured bundle
    logic [NUM_SLOTS-1:0] ld_q;
    logic [NUM_SLOTS-1:0] st_q;
    logic [NUM_SLOTS-1:0] sext_q;
    logic [31:0]          addr_q  [NUM_SLOTS];
    logic [31:0]          wdata_q [NUM_SLOTS];
    logic [1:0]           size_q  [NUM_SLOTS];
    logic [REG_IDX_W-1:0] dest_q  [NUM_SLOTS];

    // Operation currently on the bus
    logic                 cur_store;
    logic                 cur_sext;
    logic [1:0]           cur_size;
    logic [31:0]          cur_data;
    logic [REG_IDX_W-1:0] cur_dest;
    logic [1:0]           beat;
    logic [1:0]           last_beat;
    logic [31:0]          asm_q;

    // Slot selected by the scan pointer
    logic                 slot_act;
    logic                 slot_st;
    logic                 slot_sext;
    logic [1:0]           slot_size;
    logic [31:0]          slot_addr;
    logic [31:0]          slot_wdata;
    logic [REG_IDX_W-1:0] slot_dest;

    logic [1:0]           next_beat;
    logic [31:0]          ld_word;
    logic [31:0]          wb_next;

    // Mux the pointed-to slot by comparison so the past-the-end pointer value
    // never indexes outside the capture arrays.
    always_comb begin
        slot_act   = 1'b0;
        slot_st    = 1'b0;
        slot_sext  = 1'b0;
        slot_size  = '0;
        slot_addr  = '0;
        slot_wdata = '0;
        slot_dest  = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (ptr == PTR_W'(i)) begin
                slot_act   = ld_q[i] | st_q[i];
                slot_st    = st_q[i];
                slot_sext  = sext_q[i];
                slot_size  = size_q[i];
                slot_addr  = addr_q[i];
                slot_wdata = wdata_q[i];
                slot_dest  = dest_q[i];
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;

    // Alignment test for the pointed-to slot
    always_comb begin
        misaligned = 1'b0;
        if (slot_size == 2'd1)
            misaligned = slot_addr[0];
        else if (slot_size[1])
            misaligned = |slot_addr[1:0];
    end
`else
    assign err = 1'b0;
`endif

    // Merge the incoming byte into the load word and extend it for writeback
    always_comb begin
        next_beat = beat + 2'd1;
        ld_word   = asm_q;
        ld_word[{beat, 3'b000} +: 8] = mem_rdata;
        case (cur_size)
            2'd0:    wb_next = cur_sext ? {{24{ld_word[7]}}, ld_word[7:0]}
                                        : {24'h000000, ld_word[7:0]};
            2'd1:    wb_next = cur_sext ? {{16{ld_word[15]}}, ld_word[15:0]}
                                        : {16'h0000, ld_word[15:0]};
            default: wb_next = ld_word;
        endcase
    end

    // Control FSM with registered bus, writeback and status outputs
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_idx    <= '0;
            wb_val    <= '0;
            ld_q      <= '0;
            st_q      <= '0;
            sext_q    <= '0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                size_q[i]  <= '0;
                dest_q[i]  <= '0;
            end
            cur_store <= 1'b0;
            cur_sext  <= 1'b0;
            cur_size  <= '0;
            cur_data  <= '0;
            cur_dest  <= '0;
            beat      <= '0;
            last_beat <= '0;
            asm_q     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            err       <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            wb_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            err      <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ld_q   <= req_load;
                        st_q   <= req_store;
                        sext_q <= req_sext;
                        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                            addr_q[i]  <= req_addr[32*i +: 32];
                            wdata_q[i] <= req_wdata[32*i +: 32];
                            size_q[i]  <= req_size[2*i +: 2];
                            dest_q[i]  <= req_dest[REG_IDX_W*i +: REG_IDX_W];
                        end
                        ptr   <= '0;
                        busy  <= 1'b1;
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (ptr == PTR_W'(NUM_SLOTS)) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (!slot_act) begin
                        ptr <= ptr + PTR_W'(1);
`ifdef LSU_MISALIGN_TRAP_EN
                    end else if (misaligned) begin
                        err <= 1'b1;
                        ptr <= ptr + PTR_W'(1);
`endif
                    end else begin
                        cur_store <= slot_st;
                        cur_sext  <= slot_sext;
                        cur_size  <= slot_size;
                        cur_data  <= slot_wdata;
                        cur_dest  <= slot_dest;
                        beat      <= '0;
                        last_beat <= slot_size[1] ? 2'd3 : {1'b0, slot_size[0]};
                        mem_req   <= 1'b1;
                        mem_we    <= slot_st;
                        mem_addr  <= slot_addr;
                        mem_wdata <= slot_st ? slot_wdata[7:0] : 8'h00;
                        state     <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (mem_ready) begin
                        if (!cur_store)
                            asm_q <= ld_word;
                        if (beat == last_beat) begin
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            if (cur_store) begin
                                ptr   <= ptr + PTR_W'(1);
                                state <= S_SCAN;
                            end else begin
                                wb_valid <= 1'b1;
                                wb_idx   <= cur_dest;
                                wb_val   <= wb_next;
                                state    <= S_WB;
                            end
                        end else begin
                            beat     <= next_beat;
                            mem_addr <= mem_addr + 32'd1;
                            if (cur_store)
                                mem_wdata <= cur_data[{next_beat, 3'b000} +: 8];
                        end
                    end
                end
                S_WB: begin
                    ptr   <= ptr + PTR_W'(1);
                    state <= S_SCAN;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vliw_lsu.sv
// Testbench for vliw_lsu: scoreboard of expected bus beats and writebacks
// produced by a bundle-level reference model, with a bus responder/monitor
// that backs the memory bus with its own byte memory.
`timescale 1ns/1ps
module tb_vliw_lsu;

    localparam int NS = 3;
    localparam int RW = 5;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [NS-1:0]     req_load;
    logic [NS-1:0]     req_store;
    logic [32*NS-1:0]  req_addr;
    logic [32*NS-1:0]  req_wdata;
    logic [2*NS-1:0]   req_size;
    logic [NS-1:0]     req_sext;
    logic [RW*NS-1:0]  req_dest;
    logic              busy, done, mem_req, mem_we, wb_valid, err;
    logic [31:0]       mem_addr, wb_val;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = 8'h00;
    logic              mem_ready = 1'b0;
    logic [RW-1:0]     wb_idx;

    always #5 clk = ~clk;

    vliw_lsu #(.NUM_SLOTS(NS), .REG_IDX_W(RW)) dut (
        .wb_clk_i (clk),
        .rst_n    (rst_n),
        .start    (start),
        .req_load (req_load),
        .req_store(req_store),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_size (req_size),
        .req_sext (req_sext),
        .req_dest (req_dest),
        .busy     (busy),
        .done     (done),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .wb_valid (wb_valid),
        .wb_idx   (wb_idx),
        .wb_val   (wb_val),
        .err      (err)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Memories: bus_mem backs the responder, ref_mem belongs to the model
    logic [7:0] bus_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction
    function automatic logic [7:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
    endfunction
    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction
    task automatic poke(input logic [31:0] a, input logic [7:0] v);
        bus_mem[a] = v;
        ref_mem[a] = v;
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } beat_t;
    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] val;
    } wbe_t;

    beat_t exp_bus[$];
    wbe_t  exp_wb[$];
    int    exp_err = 0;

    // Bundle description driven into the DUT and fed to the model
    logic [NS-1:0] t_load, t_store, t_sext;
    logic [31:0]   t_addr  [NS];
    logic [31:0]   t_wdata [NS];
    logic [1:0]    t_size  [NS];
    logic [RW-1:0] t_dest  [NS];

    task automatic clear_req();
        t_load = '0; t_store = '0; t_sext = '0;
        for (int s = 0; s < NS; s++) begin
            t_addr[s] = '0; t_wdata[s] = '0; t_size[s] = '0; t_dest[s] = '0;
        end
    endtask

    task automatic drive_req();
        req_load = t_load; req_store = t_store; req_sext = t_sext;
        for (int s = 0; s < NS; s++) begin
            req_addr[32*s +: 32]  = t_addr[s];
            req_wdata[32*s +: 32] = t_wdata[s];
            req_size[2*s +: 2]    = t_size[s];
            req_dest[RW*s +: RW]  = t_dest[s];
        end
    endtask

    task automatic drive_random_req();
        req_load  = NS'($urandom);
        req_store = NS'($urandom);
        req_sext  = NS'($urandom);
        req_addr  = {$urandom, $urandom, $urandom};
        req_wdata = {$urandom, $urandom, $urandom};
        req_size  = (2*NS)'($urandom);
        req_dest  = (RW*NS)'($urandom);
    endtask

    function automatic bit model_trap(input logic [1:0] sz, input logic [31:0] a);
        return TRAP_EN && ((sz == 2'd1 && a % 2 != 0) || (sz >= 2'd2 && a % 4 != 0));
    endfunction

    // Reference model: whole bundle, slot by slot, in program order
    task automatic model_bundle();
        exp_err = 0;
        for (int s = 0; s < NS; s++) begin
            int unsigned n;
            logic [31:0] a;
            logic [31:0] v;
            beat_t bt;
            wbe_t  we;
            n = (t_size[s] == 2'd0) ? 1 : (t_size[s] == 2'd1) ? 2 : 4;
            if (!t_load[s] && !t_store[s]) continue;
            if (model_trap(t_size[s], t_addr[s])) begin
                exp_err++;
                continue;
            end
            v = 0;
            for (int unsigned b = 0; b < n; b++) begin
                a = t_addr[s] + b;
                bt.addr = a;
                if (t_store[s]) begin
                    bt.we    = 1'b1;
                    bt.wdata = 8'((t_wdata[s] >> (8 * b)) % 256);
                    ref_mem[a] = bt.wdata;
                end else begin
                    bt.we    = 1'b0;
                    bt.wdata = 8'h00;
                    v = v + (32'(ref_rd(a)) << (8 * b));
                end
                exp_bus.push_back(bt);
            end
            if (!t_store[s]) begin
                if (t_sext[s] && n == 1 && v >= 128)   v = v + 32'hFFFFFF00;
                if (t_sext[s] && n == 2 && v >= 32768) v = v + 32'hFFFF0000;
                we.idx = t_dest[s];
                we.val = v;
                exp_wb.push_back(we);
            end
        end
    endtask

    // Bus responder and monitor
    int    rdy_mode  = 0;
    int    rdy_phase = 0;
    int    err_cnt   = 0;
    logic  hold_pend = 1'b0;
    beat_t held;
    beat_t got;
    wbe_t  wexp;
    logic  rdy;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
            mem_ready = 1'b0;
        end else begin
            if (err) err_cnt++;
            if (wb_valid) begin
                if (exp_wb.size() == 0) begin
                    n_assert++; n_fail++;
                    $display("FAIL unexpected_wb: got idx %0d val 0x%08h, required none", wb_idx, wb_val);
                end else begin
                    wexp = exp_wb.pop_front();
                    check("wb_idx", 32'(wb_idx), 32'(wexp.idx));
                    check("wb_val", wb_val, wexp.val);
                end
            end
            if (hold_pend && mem_req) begin
                check("hold_addr", mem_addr, held.addr);
                check("hold_we", 32'(mem_we), 32'(held.we));
                check("hold_wdata", 32'(mem_wdata), 32'(held.wdata));
            end
            case (rdy_mode)
                0: rdy = 1'b1;
                1: begin
                    rdy_phase = (rdy_phase + 1) % 3;
                    rdy = (rdy_phase == 0);
                end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            mem_ready = rdy;
            mem_rdata = bus_rd(mem_addr);
            if (mem_req && rdy) begin
                hold_pend = 1'b0;
                if (exp_bus.size() == 0) begin
                    n_assert++; n_fail++;
                    $display("FAIL unexpected_beat: got addr 0x%08h we %0d, required none", mem_addr, mem_we);
                end else begin
                    got = exp_bus.pop_front();
                    check("beat_addr", mem_addr, got.addr);
                    check("beat_we", 32'(mem_we), 32'(got.we));
                    if (got.we) check("beat_wdata", 32'(mem_wdata), 32'(got.wdata));
                end
                if (mem_we) bus_mem[mem_addr] = mem_wdata;
            end else if (mem_req) begin
                hold_pend  = 1'b1;
                held.addr  = mem_addr;
                held.we    = mem_we;
                held.wdata = mem_wdata;
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    task automatic run_bundle(input bit inject);
        int cyc;
        int e0;
        model_bundle();
        e0 = err_cnt;
        @(posedge clk); #1;
        drive_req();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drive_random_req();
        if (inject) begin
            repeat (2) @(posedge clk);
            #1;
            check("busy_at_inject", 32'(busy), 32'd1);
            drive_random_req();
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        cyc = 0;
        @(negedge clk);
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            n_assert++; n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done pulse", cyc);
        end else begin
            check("busy_at_done", 32'(busy), 32'd1);
            @(negedge clk);
            check("busy_after_done", 32'(busy), 32'd0);
            check("done_pulse_width", 32'(done), 32'd0);
        end
        check("bus_left", 32'(exp_bus.size()), 32'd0);
        check("wb_left", 32'(exp_wb.size()), 32'd0);
        check("err_count", 32'(err_cnt - e0), 32'(exp_err));
        exp_bus.delete();
        exp_wb.delete();
    endtask

    task automatic random_bundle();
        int unsigned k;
        clear_req();
        for (int s = 0; s < NS; s++) begin
            k = $urandom_range(0, 3);
            t_load[s]  = (k == 1 || k == 3);
            t_store[s] = (k == 2 || k == 3);
            t_addr[s]  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3)
                                                      : 32'h1000 + $urandom_range(0, 23);
            t_size[s]  = 2'($urandom_range(0, 3));
            t_sext[s]  = 1'($urandom_range(0, 1));
            t_dest[s]  = RW'($urandom_range(0, 31));
            t_wdata[s] = $urandom;
        end
    endtask

    initial begin
        int cyc;
        clear_req();
        drive_req();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_idx", 32'(wb_idx), 32'd0);
        check("rst_wb_val", wb_val, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // Byte load, slot 0, signed then unsigned
        rdy_mode = 0;
        poke(32'h40, 8'h80);
        clear_req();
        t_load[0] = 1'b1; t_addr[0] = 32'h40; t_sext[0] = 1'b1; t_dest[0] = 5'd7;
        run_bundle(1'b0);
        t_sext[0] = 1'b0;
        run_bundle(1'b0);

        // Word store, slot 1
        clear_req();
        t_store[1] = 1'b1; t_addr[1] = 32'h100; t_wdata[1] = 32'h11223344; t_size[1] = 2'd2;
        run_bundle(1'b0);

        // Three slots with ready every third cycle, start pulsed while busy
        rdy_mode = 1;
        poke(32'h200, 8'hFE);
        poke(32'h201, 8'hFF);
        clear_req();
        t_load[0] = 1'b1; t_addr[0] = 32'h200; t_size[0] = 2'd1; t_sext[0] = 1'b1; t_dest[0] = 5'd3;
        t_store[2] = 1'b1; t_addr[2] = 32'h300; t_wdata[2] = 32'h000000AB; t_size[2] = 2'd0;
        run_bundle(1'b1);

        // Load and store both set on one slot: store wins
        rdy_mode = 0;
        clear_req();
        t_load[1] = 1'b1; t_store[1] = 1'b1; t_addr[1] = 32'h480; t_size[1] = 2'd1;
        t_wdata[1] = 32'h0000BEEF; t_dest[1] = 5'd9;
        run_bundle(1'b0);

        // Misaligned word load
        clear_req();
        t_load[0] = 1'b1; t_addr[0] = 32'h102; t_size[0] = 2'd2; t_dest[0] = 5'd12;
        run_bundle(1'b0);

        // Empty bundle
        clear_req();
        run_bundle(1'b0);

        // Address wrap, and store-to-load forwarding through memory
        clear_req();
        t_store[0] = 1'b1; t_addr[0] = 32'hFFFFFFFF; t_size[0] = 2'd1; t_wdata[0] = 32'h00005AA5;
        t_store[1] = 1'b1; t_addr[1] = 32'h1000; t_size[1] = 2'd3; t_wdata[1] = 32'hCAFEF00D;
        t_load[2]  = 1'b1; t_addr[2] = 32'h1000; t_size[2] = 2'd2; t_dest[2] = 5'd31;
        run_bundle(1'b0);
        clear_req();
        t_load[0] = 1'b1; t_addr[0] = 32'hFFFFFFFE; t_size[0] = 2'd2; t_dest[0] = 5'd1;
        run_bundle(1'b0);

        // Reset during the second beat of a word load
        clear_req();
        t_load[0] = 1'b1; t_addr[0] = 32'h500; t_size[0] = 2'd2; t_dest[0] = 5'd5;
        model_bundle();
        @(posedge clk); #1;
        drive_req();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!mem_req && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rst_test_req_seen", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_wb_valid", 32'(wb_valid), 32'd0);
        exp_bus.delete();
        exp_wb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("postrst_mem_req", 32'(mem_req), 32'd0);
            check("postrst_busy", 32'(busy), 32'd0);
            check("postrst_wb_valid", 32'(wb_valid), 32'd0);
        end
        run_bundle(1'b0);

        // Randomised bundles with random ready
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            random_bundle();
            run_bundle(1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
